vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 Hz VGA raster timing from the system clock.
- Produces pixel_x/pixel_y for the frame-buffer and text-console stages that sit directly downstream.
- Produces hsync/vsync/video_on for the output mux.
- Divides clk into a pixel-enable tick; all outputs are registered or decoded only from registered counters.

Parameters:
CLK_DIV, 2, clk cycles per pixel (>=2); 50 MHz clk gives 25 MHz pixel rate
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
p_tick  output  1  one-clk pulse per pixel period
pixel_x  output  10  horizontal count, 0..H_TOTAL-1
pixel_y  output  10  vertical count, 0..V_TOTAL-1
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
video_on  output  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
line_start  output  1  one-clk pulse on the first clk with pixel_x==0
frame_start  output  1  one-clk pulse on the first clk with pixel_x==0 and pixel_y==0

Behaviour:
- Derived constants: H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - p_tick is high exactly in clk cycles where div_cnt==CLK_DIV-1.
- Horizontal counter:
  - Advances only on p_tick.
  - At H_TOTAL-1 it wraps to 0 and raises h_end.
- Vertical counter:
  - Advances only on p_tick with h_end.
  - At V_TOTAL-1 it wraps to 0.
- Counter width: both counters are 10 bits. Assertion: H_TOTAL<=1024 and V_TOTAL<=1024.
- Sync and blanking decodes (combinational from the registered counters, so no input-to-output path):
  - hsync = 0 iff H_DISPLAY+H_FRONT <= pixel_x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync = 0 iff V_DISPLAY+V_FRONT <= pixel_y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
- line_start / frame_start: registered. Asserted for exactly one clk, in the first clk after the counter update to pixel_x==0 (and pixel_y==0 for frame_start). Never asserted in any other clk of that pixel period.
- Downstream RAM timing: pixel_x/pixel_y are stable for CLK_DIV clks. A downstream synchronous RAM read (1 clk latency) therefore returns data inside the same pixel period when CLK_DIV>=2.
- Reset values:
  - div_cnt=0, pixel_x=0, pixel_y=0.
  - p_tick=0, hsync=1, vsync=1, video_on=1.
  - line_start=0, frame_start=0.
  - line_irq=0 (when the optional feature is enabled).
- Reset mid-frame: in the clk after reset is sampled high, all state equals the reset values. No partial line and no sync pulse is emitted during reset.
- After reset deasserts:
  - The first p_tick occurs CLK_DIV clks later.
  - The first line_start/frame_start pulses occur at the first wrap to (0,0), not at reset release.
- Simultaneous h_end and v wrap: both counters go to 0 on the same p_tick; line_start and frame_start pulse in the same clk.

Optional Feature:
- Macro: VGA_TIMING_LINE_IRQ_EN
- Defined:
  - Adds input line_cmp[9:0] and output line_irq.
  - line_irq is registered and pulses for one clk when pixel_y changes to a value equal to line_cmp, coincident with line_start.
  - line_cmp is sampled at each line_start; changes mid-line take effect from the next line.
  - line_cmp>=V_TOTAL never fires.
- Undefined: the ports are absent, no extra flops are built, and all other behaviour is identical.

Test Plan:
1. Hold reset 5 clks, release -> outputs equal the reset values during reset; first p_tick at clk 2 after release; pixel_x=1 at clk 2; period of p_tick = 2 clks.
2. Run one full line -> pixel_x sequences 0..799 then 0; hsync low for exactly 96 pixels (192 clks) starting at pixel_x=656; video_on low from pixel_x=640.
3. Run one full frame -> frame period 800*525*2 = 840000 clks; vsync low for 2 lines (1600 pixels) at pixel_y=490..491; frame_start pulses once per frame, 1 clk wide.
4. Assert reset at pixel_x=700, pixel_y=300 for 1 clk -> next clk shows pixel_x=0, pixel_y=0, hsync=1, vsync=1, no line_start until the next wrap.
5. Check last pixel of frame at (799,524) -> on next p_tick pixel_x=0 and pixel_y=0 together; line_start and frame_start high in the same single clk.
6. With VGA_TIMING_LINE_IRQ_EN, line_cmp=100 -> line_irq one clk at the line_start where pixel_y=100, once per frame; line_cmp=600 -> never fires; build without the macro -> ports absent, tests 1–5 unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync/blank decodes, line/frame pulses.
// Optional raster-line interrupt (line_cmp/line_irq) is built when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
`ifdef VGA_TIMING_LINE_IRQ_EN
   input  logic [9:0] line_cmp,
   output logic       line_irq,
`endif
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
   // 11-bit bounds so an end value of exactly 1024 still compares correctly
   localparam logic [10:0]   H_VIS    = 11'(H_DISPLAY);
   localparam logic [10:0]   V_VIS    = 11'(V_DISPLAY);
   localparam logic [10:0]   HS_START = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0]   HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0]   VS_START = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0]   VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

   if (H_TOTAL > 1024) begin : g_h_range
      $error("vga_timing_gen: H_TOTAL does not fit the 10-bit counter");
   end
   if (V_TOTAL > 1024) begin : g_v_range
      $error("vga_timing_gen: V_TOTAL does not fit the 10-bit counter");
   end
   if (CLK_DIV < 2) begin : g_div_range
      $error("vga_timing_gen: CLK_DIV must be at least 2");
   end

   logic [DW-1:0] div_q, div_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          line_start_q, line_start_d;
   logic          frame_start_q, frame_start_d;
   logic          tick;
   logic          h_end;

   always_comb begin
      tick          = (div_q == DIV_LAST);
      h_end         = (x_q == H_LAST);
      div_d         = tick ? '0 : div_q + DW'(1);
      x_d           = x_q;
      y_d           = y_q;
      if (tick) begin
         if (h_end) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
         end else begin
            x_d = x_q + 10'd1;
         end
      end
      line_start_d  = tick && h_end;
      frame_start_d = tick && h_end && (y_q == V_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q         <= '0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         div_q         <= div_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_TIMING_LINE_IRQ_EN
   // Compare value is captured at each line wrap and used at the following wrap;
   // the all-ones reset value lies outside any legal line so nothing fires early.
   logic [9:0] cmp_q;
   logic       irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_q <= '1;
         irq_q <= 1'b0;
      end else begin
         irq_q <= line_start_d && (y_d == cmp_q);
         if (line_start_d) begin
            cmp_q <= line_cmp;
         end
      end
   end

   assign line_irq = irq_q;
`endif

   assign p_tick      = tick;
   assign pixel_x     = x_q;
   assign pixel_y     = y_q;
   assign hsync       = !(({1'b0, x_q} >= HS_START) && ({1'b0, x_q} < HS_END));
   assign vsync       = !(({1'b0, y_q} >= VS_START) && ({1'b0, y_q} < VS_END));
   assign video_on    = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule
